// File: rtl/shift_register_piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package shift_register_piso_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Bits needed to count down from width-1 to zero.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/shift_register_piso_bit_counter.sv
// Loadable down-counter for the PISO bit position; flags zero.
module piso_bit_counter #(
   parameter int unsigned           CNT_W    = 3,
   parameter logic [CNT_W-1:0]      LOAD_VAL = '1
) (
   input  logic Ck,
   input  logic ResetN,
   input  logic load,
   input  logic enable,
   output logic zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge Ck or negedge ResetN) begin
      if (!ResetN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out transmitter with Load/Ready intake and Valid/Done framing.
module shift_register_piso
   import shift_register_piso_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             Ck,
   input  logic             ResetN,
   input  logic             Load,
   input  logic [WIDTH-1:0] Din,
   output logic             Ready,
   output logic             Q,
   output logic             QN,
   output logic             Valid,
   output logic             Done
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic             cnt_zero;
   logic             cnt_load;
   logic             cnt_en;
   logic             accept;
   logic             head;

   piso_bit_counter #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (LAST_IDX)
   ) u_bit_counter (
      .Ck     (Ck),
      .ResetN (ResetN),
      .load   (cnt_load),
      .enable (cnt_en),
      .zero   (cnt_zero)
   );

   // Outputs decode registered state only; Load/Din never reach them.
   always_comb begin
      head   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      Valid  = (state_q == ST_SHIFT);
      Done   = Valid & cnt_zero;
      Ready  = (state_q == ST_IDLE) | Done;
      Q      = Valid & head;
      QN     = ~Q;
      accept = Load & Ready;
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      if (accept) begin
         state_d  = ST_SHIFT;
         shreg_d  = Din;
         cnt_load = 1'b1;
      end else if (state_q == ST_SHIFT) begin
         shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};
         if (cnt_zero) begin
            state_d = ST_IDLE;
         end else begin
            cnt_en = 1'b1;
         end
      end
   end

   always_ff @(posedge Ck or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: tb/tb_shift_register_piso.sv
// Directed vector bench for shift_register_piso (MSB-first and LSB-first instances).
module tb_shift_register_piso;

   typedef struct {
      logic       rst_n;
      logic       load;
      logic [7:0] din;
      logic       exp_q;
      logic       exp_valid;
      logic       exp_ready;
      logic       exp_done;
   } vec_t;

   logic       Ck;
   logic       ResetN;
   logic       Load;
   logic [7:0] Din;
   logic       Ready, Q, QN, Valid, Done;

   logic       load_l;
   logic [7:0] din_l;
   logic       ready_l, q_l, qn_l, valid_l, done_l;

   int unsigned total;
   int unsigned passed;
   vec_t        vecs[$];

   shift_register_piso #(
      .WIDTH     (8),
      .MSB_FIRST (1'b1)
   ) u_dut (
      .Ck     (Ck),
      .ResetN (ResetN),
      .Load   (Load),
      .Din    (Din),
      .Ready  (Ready),
      .Q      (Q),
      .QN     (QN),
      .Valid  (Valid),
      .Done   (Done)
   );

   shift_register_piso #(
      .WIDTH     (8),
      .MSB_FIRST (1'b0)
   ) u_lsb (
      .Ck     (Ck),
      .ResetN (ResetN),
      .Load   (load_l),
      .Din    (din_l),
      .Ready  (ready_l),
      .Q      (q_l),
      .QN     (qn_l),
      .Valid  (valid_l),
      .Done   (done_l)
   );

   initial Ck = 1'b0;
   always #5 Ck = ~Ck;

   task automatic chk(input string name, input logic got, input logic exp);
      total++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag,
                           input logic aq, input logic aqn, input logic av,
                           input logic ar, input logic ad,
                           input logic eq, input logic ev, input logic er, input logic ed);
      chk({tag, "_Q"},     aq,  eq);
      chk({tag, "_QN"},    aqn, ~eq);
      chk({tag, "_Valid"}, av,  ev);
      chk({tag, "_Ready"}, ar,  er);
      chk({tag, "_Done"},  ad,  ed);
   endtask

   task automatic add_row(input logic rst_n, input logic load, input logic [7:0] din,
                          input logic q, input logic v, input logic r, input logic d);
      vec_t row;
      row.rst_n     = rst_n;
      row.load      = load;
      row.din       = din;
      row.exp_q     = q;
      row.exp_valid = v;
      row.exp_ready = r;
      row.exp_done  = d;
      vecs.push_back(row);
   endtask

   // One word, MSB first; Load=1 with Din=0F is also driven during cycles busy_lo..busy_hi.
   task automatic add_word(input logic [7:0] w, input int unsigned busy_lo,
                           input int unsigned busy_hi);
      for (int unsigned j = 0; j < 8; j++) begin
         add_row(1'b1,
                 (j == 0) || (j >= busy_lo && j <= busy_hi),
                 (j == 0) ? w : 8'h0F,
                 w[7-j], 1'b1, (j == 7), (j == 7));
      end
   endtask

   initial begin
      logic [7:0] w;
      total  = 0;
      passed = 0;
      ResetN = 1'b0;
      Load   = 1'b1;
      Din    = 8'hFF;
      load_l = 1'b0;
      din_l  = 8'h00;

      // Reset held across three edges with Load asserted
      for (int i = 0; i < 3; i++) add_row(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      // Single word A5, then idle
      add_word(8'hA5, 1, 0);
      add_row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      // Back-to-back A5 then 3C, then idle
      add_word(8'hA5, 1, 0);
      add_word(8'h3C, 1, 0);
      add_row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      // F0 with Load/Din=0F driven in cycles 2..7, then idle
      add_word(8'hF0, 2, 7);
      add_row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      @(negedge Ck);
      chk_outs("reset_async", Q, QN, Valid, Ready, Done, 1'b0, 1'b0, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         ResetN = vecs[i].rst_n;
         Load   = vecs[i].load;
         Din    = vecs[i].din;
         @(posedge Ck);
         @(negedge Ck);
         chk_outs($sformatf("row%0d", i), Q, QN, Valid, Ready, Done,
                  vecs[i].exp_q, vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_done);
      end

      // Asynchronous reset in cycle 4 of an FF word
      Load = 1'b1;
      Din  = 8'hFF;
      @(posedge Ck);
      @(negedge Ck);
      Load = 1'b0;
      chk_outs("ff_c1", Q, QN, Valid, Ready, Done, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge Ck);
      @(posedge Ck);
      #2 ResetN = 1'b0;
      #1 chk_outs("midrst", Q, QN, Valid, Ready, Done, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (2) @(posedge Ck);
      @(negedge Ck);
      ResetN = 1'b1;
      Load   = 1'b1;
      Din    = 8'h81;
      w      = 8'h81;
      for (int unsigned j = 0; j < 8; j++) begin
         @(posedge Ck);
         @(negedge Ck);
         Load = 1'b0;
         chk_outs($sformatf("w81_c%0d", j + 1), Q, QN, Valid, Ready, Done,
                  w[7-j], 1'b1, (j == 7), (j == 7));
      end
      @(posedge Ck);
      @(negedge Ck);
      chk_outs("w81_idle", Q, QN, Valid, Ready, Done, 1'b0, 1'b0, 1'b1, 1'b0);

      // LSB-first instance: 01 goes out as 1 then seven 0s
      load_l = 1'b1;
      din_l  = 8'h01;
      for (int unsigned j = 0; j < 8; j++) begin
         @(posedge Ck);
         @(negedge Ck);
         load_l = 1'b0;
         chk_outs($sformatf("lsb_c%0d", j + 1), q_l, qn_l, valid_l, ready_l, done_l,
                  (j == 0), 1'b1, (j == 7), (j == 7));
      end
      @(posedge Ck);
      @(negedge Ck);
      chk_outs("lsb_idle", q_l, qn_l, valid_l, ready_l, done_l, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
